// File: rtl/step_clock_ctrl_pkg.sv
// Shared encodings and defaults for the step clock controller.
// Holds the mode codes, the default debounce length and the step_clk state type.
package step_clock_ctrl_pkg;

    localparam logic [1:0] MODE_SINGLE = 2'd0;
    localparam logic [1:0] MODE_RUN    = 2'd1;
    localparam logic [1:0] MODE_BURST  = 2'd2;

    localparam int DEBOUNCE_DEFAULT = 5000;

    typedef enum logic [1:0] {
        CLK_IDLE,
        CLK_HIGH,
        CLK_GUARD
    } clk_state_e;

endpackage

// File: rtl/step_clock_ctrl_btn_debounce.sv
// One button channel: 2-FF synchroniser, stability counter, level, rise pulse.
// Ports: clk_i, rst_ni (async, active-low), btn_i -> level_o, pulse_o.
module step_clock_ctrl_btn_debounce
    import step_clock_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic level_o,
    output logic pulse_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          meta_q;
    logic          sync_q;
    logic          level_q;
    logic          level_d;
    logic          pulse_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Any sample that agrees with the current level restarts the count,
    // so only an unbroken run of disagreeing samples moves the level.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d = sync_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            meta_q  <= btn_i;
            sync_q  <= meta_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= level_d & ~level_q;
        end
    end

    assign level_o = level_q;
    assign pulse_o = pulse_q;

endmodule

// File: rtl/step_clock_ctrl.sv
// Single-step / run / burst clock controller for the CPU board top level.
// Ports: clk, reset, btn, mode, halt, run_div, burst_len -> btn_level, btn_pulse, step_en, step_clk, ticks, busy.
module step_clock_ctrl
    import step_clock_ctrl_pkg::*;
#(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int STRETCH         = 8,
    parameter int TICK_W          = 8,
    parameter int BURST_W         = 8,
    parameter int DIV_W           = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_BTN-1:0]   btn,
    input  logic [1:0]         mode,
    input  logic               halt,
    input  logic [DIV_W-1:0]   run_div,
    input  logic [BURST_W-1:0] burst_len,
    output logic [N_BTN-1:0]   btn_level,
    output logic [N_BTN-1:0]   btn_pulse,
    output logic               step_en,
    output logic               step_clk,
    output logic [TICK_W-1:0]  ticks,
    output logic               busy
);

    localparam int SW = (STRETCH > 1) ? $clog2(STRETCH) : 1;
    localparam logic [SW-1:0] S_LOAD = SW'(STRETCH - 1);

    clk_state_e         st_q;
    logic [SW-1:0]      scnt_q;
    logic               step_en_q;
    logic               step_clk_q;
    logic               busy_q;
    logic [TICK_W-1:0]  ticks_q;
    logic [DIV_W-1:0]   pace_q;
    logic [BURST_W-1:0] rem_q;

    logic [DIV_W-1:0]   div_m1;
    logic               expired;
    logic               ready;
    logic               pacing;
    logic               is_single;
    logic               issue;
    logic               burst_go;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        step_clock_ctrl_btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk_i  (clk),
            .rst_ni (reset),
            .btn_i  (btn[i]),
            .level_o(btn_level[i]),
            .pulse_o(btn_pulse[i])
        );
    end

    // Ready already in the last guard cycle, so back-to-back steps are
    // exactly STRETCH high plus STRETCH low apart.
    always_comb begin
        div_m1    = (run_div == '0) ? '0 : run_div - DIV_W'(1);
        expired   = (pace_q >= div_m1);
        ready     = (st_q == CLK_IDLE) ||
                    ((st_q == CLK_GUARD) && (scnt_q == '0));
        pacing    = (mode == MODE_RUN) || ((mode == MODE_BURST) && busy_q);
        is_single = (mode != MODE_RUN) && (mode != MODE_BURST);
        issue     = 1'b0;
        if (!halt && ready) begin
            issue = is_single ? btn_pulse[0] : (pacing && expired);
        end
        burst_go  = (mode == MODE_BURST) && !busy_q &&
                    btn_pulse[0] && (burst_len != '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q       <= CLK_IDLE;
            scnt_q     <= '0;
            step_en_q  <= 1'b0;
            step_clk_q <= 1'b0;
            busy_q     <= 1'b0;
            ticks_q    <= '0;
            pace_q     <= '0;
            rem_q      <= '0;
        end else begin
            step_en_q <= issue;

            if (issue) begin
                st_q       <= CLK_HIGH;
                step_clk_q <= 1'b1;
                scnt_q     <= S_LOAD;
                ticks_q    <= ticks_q + TICK_W'(1);
            end else begin
                unique case (st_q)
                    CLK_HIGH: begin
                        if (scnt_q == '0) begin
                            st_q       <= CLK_GUARD;
                            step_clk_q <= 1'b0;
                            scnt_q     <= S_LOAD;
                        end else begin
                            scnt_q <= scnt_q - SW'(1);
                        end
                    end
                    CLK_GUARD: begin
                        if (scnt_q == '0) begin
                            st_q <= CLK_IDLE;
                        end else begin
                            scnt_q <= scnt_q - SW'(1);
                        end
                    end
                    default: st_q <= CLK_IDLE;
                endcase
            end

            // Saturates at expiry so a blocked step stays pending.
            if (!pacing || issue) begin
                pace_q <= '0;
            end else if (!halt && !expired) begin
                pace_q <= pace_q + DIV_W'(1);
            end

            if (mode != MODE_BURST) begin
                busy_q <= 1'b0;
                rem_q  <= '0;
            end else if (burst_go) begin
                busy_q <= 1'b1;
                rem_q  <= burst_len;
            end else if (busy_q && issue) begin
                rem_q <= rem_q - BURST_W'(1);
                if (rem_q == BURST_W'(1)) begin
                    busy_q <= 1'b0;
                end
            end
        end
    end

    assign step_en  = step_en_q;
    assign step_clk = step_clk_q;
    assign ticks    = ticks_q;
    assign busy     = busy_q;

endmodule
